// File: rtl/pool_pkg.sv
// Shared types, limits and the output-size helper for the pooling sequencer.
package pool_pkg;
    localparam int K_MAX      = 3;
    localparam int S_MAX      = 3;
    localparam int K_W        = $clog2(K_MAX + 1);
    localparam int S_W        = $clog2(S_MAX + 1);
    // Field widths of the latched configuration; module parameters must not exceed them.
    localparam int CFG_DIM_W  = 6;
    localparam int CFG_ADDR_W = 12;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, HOLD, DRAIN, DONE} state_e;
    typedef enum logic [1:0] {STEP_KX, STEP_KY, STEP_OX, STEP_OY} step_e;

    typedef struct packed {
        logic [CFG_DIM_W-1:0]  h;
        logic [CFG_DIM_W-1:0]  w;
        logic [K_W-1:0]        k;
        logic [S_W-1:0]        s;
        logic [CFG_ADDR_W-1:0] rd_base;
        logic [CFG_ADDR_W-1:0] wr_base;
    } cfg_t;

    // Number of window positions along one dimension: (d - k) / s + 1.
    function automatic logic [CFG_DIM_W-1:0] out_dim(input logic [CFG_DIM_W-1:0] d,
                                                     input logic [K_W-1:0]       k,
                                                     input logic [S_W-1:0]       s);
        logic [CFG_DIM_W-1:0] span;
        logic [CFG_DIM_W-1:0] q;
        span = d - CFG_DIM_W'(k);
        case (s)
            2'd2:    q = span >> 1;
            2'd3:    q = span / CFG_DIM_W'(3);
            default: q = span;
        endcase
        return q + CFG_DIM_W'(1);
    endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// Incremental read/write address counters; the read address is built from
// row-start and window-start registers so no multiplier sits on the step path.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  step_e                 mode_i,
    input  logic [CFG_DIM_W-1:0]  w_i,
    input  logic [K_W-1:0]        k_i,
    input  logic [S_W-1:0]        s_i,
    input  logic [CFG_ADDR_W-1:0] rd_base_i,
    input  logic [CFG_ADDR_W-1:0] wr_base_i,
    output logic [ADDR_W-1:0]     rd_addr_o,
    output logic [ADDR_W-1:0]     wr_addr_o
);
    logic [ADDR_W-1:0] rd_q, rd_d, win_q, win_d, row_q, row_d, wr_q, wr_d, sw_q, sw_d;
    logic [ADDR_W-1:0] w_ext, s_ext, k_m1;

    assign w_ext = ADDR_W'(w_i);
    assign s_ext = ADDR_W'(s_i);
    assign k_m1  = ADDR_W'(k_i) - ADDR_W'(1);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        rd_d  = rd_q;
        win_d = win_q;
        row_d = row_q;
        wr_d  = wr_q;
        sw_d  = sw_q;
        if (load_i) begin
            rd_d  = ADDR_W'(rd_base_i);
            win_d = ADDR_W'(rd_base_i);
            row_d = ADDR_W'(rd_base_i);
            wr_d  = ADDR_W'(wr_base_i);
            // s*w is fixed per job, so it is formed once here with shifts and an add.
            case (s_i)
                2'd1:    sw_d = w_ext;
                2'd2:    sw_d = w_ext << 1;
                default: sw_d = w_ext + (w_ext << 1);
            endcase
        end else if (step_i) begin
            case (mode_i)
                STEP_KX: rd_d = rd_q + ADDR_W'(1);
                STEP_KY: rd_d = rd_q + w_ext - k_m1;
                STEP_OX: begin
                    win_d = win_q + s_ext;
                    rd_d  = win_d;
                    wr_d  = wr_q + ADDR_W'(1);
                end
                default: begin
                    row_d = row_q + sw_q;
                    win_d = row_d;
                    rd_d  = row_d;
                    wr_d  = wr_q + ADDR_W'(1);
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            win_q <= '0;
            row_q <= '0;
            wr_q  <= '0;
            sw_q  <= '0;
        end else begin
            rd_q  <= rd_d;
            win_q <= win_d;
            row_q <= row_d;
            wr_q  <= wr_d;
            sw_q  <= sw_d;
        end
    end

    assign rd_addr_o = rd_q;
    assign wr_addr_o = wr_q;
endmodule

// File: rtl/pool_ctrl.sv
// Pooling-window sequencer: FSM, window counters and the strobe pipeline that
// aligns first/last/valid with activation read data.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DIM_W  = CFG_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [1:0]        cfg_k,
    input  logic [1:0]        cfg_s,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pool_vld,
    output logic              pool_first,
    output logic              pool_last,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready
);
    state_e               state_q, state_d;
    cfg_t                 cfg_q, cfg_d;
    logic [CFG_DIM_W-1:0] ho_q, ho_d, wo_q, wo_d, ox_q, ox_d, oy_q, oy_d;
    logic [K_W-1:0]       kx_q, kx_d, ky_q, ky_d;
    logic                 err_d, gen_load, gen_step, cfg_bad;
    logic                 last_kx, last_ky, last_ox, last_oy, last_win, last_all;
    step_e                gen_mode;
    logic [ADDR_W-1:0]    gen_wr_addr;
    logic                 busy_q, done_q, err_q, rd_en_q, vld_q, first_q, last_q;
    logic [ADDR_W-1:0]    wr_addr_q;

    assign cfg_bad  = (cfg_q.k == '0) || (cfg_q.s == '0) ||
                      (CFG_DIM_W'(cfg_q.k) > cfg_q.h) || (CFG_DIM_W'(cfg_q.k) > cfg_q.w);
    assign last_kx  = (kx_q == cfg_q.k - K_W'(1));
    assign last_ky  = (ky_q == cfg_q.k - K_W'(1));
    assign last_ox  = (ox_q == wo_q - CFG_DIM_W'(1));
    assign last_oy  = (oy_q == ho_q - CFG_DIM_W'(1));
    assign last_win = last_kx && last_ky;
    assign last_all = last_win && last_ox && last_oy;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        ho_d     = ho_q;
        wo_d     = wo_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        kx_d     = kx_q;
        ky_d     = ky_q;
        err_d    = 1'b0;
        gen_load = 1'b0;
        gen_step = 1'b0;
        gen_mode = STEP_KX;
        case (state_q)
            IDLE: if (start) begin
                cfg_d.h       = CFG_DIM_W'(cfg_h);
                cfg_d.w       = CFG_DIM_W'(cfg_w);
                cfg_d.k       = cfg_k;
                cfg_d.s       = cfg_s;
                cfg_d.rd_base = CFG_ADDR_W'(cfg_rd_base);
                cfg_d.wr_base = CFG_ADDR_W'(cfg_wr_base);
                state_d       = CHECK;
            end
            CHECK: if (cfg_bad) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                ho_d     = out_dim(cfg_q.h, cfg_q.k, cfg_q.s);
                wo_d     = out_dim(cfg_q.w, cfg_q.k, cfg_q.s);
                ox_d     = '0;
                oy_d     = '0;
                kx_d     = '0;
                ky_d     = '0;
                gen_load = 1'b1;
                state_d  = wr_ready ? RUN : HOLD;
            end
            RUN: if (last_all) begin
                state_d = DRAIN;
            end else begin
                // Counters advance to the next read; a new window waits for output space.
                gen_step = 1'b1;
                if (!last_kx) begin
                    gen_mode = STEP_KX;
                    kx_d     = kx_q + K_W'(1);
                end else if (!last_ky) begin
                    gen_mode = STEP_KY;
                    kx_d     = '0;
                    ky_d     = ky_q + K_W'(1);
                end else if (!last_ox) begin
                    gen_mode = STEP_OX;
                    kx_d     = '0;
                    ky_d     = '0;
                    ox_d     = ox_q + CFG_DIM_W'(1);
                end else begin
                    gen_mode = STEP_OY;
                    kx_d     = '0;
                    ky_d     = '0;
                    ox_d     = '0;
                    oy_d     = oy_q + CFG_DIM_W'(1);
                end
                state_d = (last_win && !wr_ready) ? HOLD : RUN;
            end
            HOLD:    if (wr_ready) state_d = RUN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            ho_q    <= '0;
            wo_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            ho_q    <= ho_d;
            wo_q    <= wo_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
        end
    end

    // Control outputs come from next-state; datapath strobes trail rd_en by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
            rd_en_q <= (state_d == RUN);
            vld_q   <= rd_en_q;
            first_q <= rd_en_q && (kx_q == '0) && (ky_q == '0);
            last_q  <= rd_en_q && last_win;
            if (rd_en_q) wr_addr_q <= gen_wr_addr;
        end
    end

    pool_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (gen_load),
        .step_i    (gen_step),
        .mode_i    (gen_mode),
        .w_i       (cfg_q.w),
        .k_i       (cfg_q.k),
        .s_i       (cfg_q.s),
        .rd_base_i (cfg_q.rd_base),
        .wr_base_i (cfg_q.wr_base),
        .rd_addr_o (rd_addr),
        .wr_addr_o (gen_wr_addr)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = err_q;
    assign rd_en      = rd_en_q;
    assign pool_vld   = vld_q;
    assign pool_first = first_q;
    assign pool_last  = last_q;
    assign wr_addr    = wr_addr_q;
endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: table of tile configurations plus
// hand-written backpressure, busy-restart and reset sequences.
module tb_pool_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, wr_ready;
    logic [5:0]  cfg_h, cfg_w;
    logic [1:0]  cfg_k, cfg_s;
    logic [11:0] cfg_rd_base, cfg_wr_base;
    logic        busy, done, cfg_err, rd_en, pool_vld, pool_first, pool_last;
    logic [11:0] rd_addr, wr_addr;

    pool_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_k(cfg_k), .cfg_s(cfg_s),
        .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
        .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en), .rd_addr(rd_addr),
        .pool_vld(pool_vld), .pool_first(pool_first), .pool_last(pool_last),
        .wr_addr(wr_addr), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int h; int w; int k; int s; int rb; int wb;
        int reads; int wins; int done_at; bit err;
    } vec_t;

    vec_t vecs[12];
    int   n_tests = 0, n_fail = 0;
    int   c0 = 0, hold_lo = 1, hold_hi = 0, spur_rel = -1;
    int   rd_log[$], rdc_log[$], wr_log[$], exp_rd[$], exp_wr[$];
    int   n_vld, n_first, n_last, n_both, n_done, n_err;
    int   first_vld, done_cyc, err_cyc;
    logic busy_pre, busy1, busy_at_done, busy_after;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int act[$], input int exp[$]);
        int bad = -1;
        n_tests++;
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            if (bad < 0 && act[i] != exp[i]) bad = i;
        if (bad < 0 && act.size() != exp.size()) bad = (act.size() < exp.size()) ? act.size() : exp.size();
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: index %0d got %0d (len %0d), expected %0d (len %0d)", name, bad,
                     (bad < act.size()) ? act[bad] : -1, act.size(),
                     (bad < exp.size()) ? exp[bad] : -1, exp.size());
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // One clock: sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic tick();
        int rel;
        @(negedge clk);
        rel = cyc - c0;
        if (rd_en) begin
            rd_log.push_back(int'(rd_addr));
            rdc_log.push_back(rel);
        end
        if (pool_vld) begin
            n_vld++;
            if (first_vld < 0) first_vld = rel;
        end
        if (pool_vld && pool_first) n_first++;
        if (pool_vld && pool_last) begin
            n_last++;
            wr_log.push_back(int'(wr_addr));
        end
        if (pool_vld && pool_first && pool_last) n_both++;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = rel;
            busy_at_done = busy;
        end
        if (cfg_err) begin
            n_err++;
            err_cyc = rel;
        end
        if (rel == 1) busy1 = busy;
        if (done_cyc >= 0 && rel == done_cyc + 1) busy_after = busy;
        wr_ready = (rel < hold_lo || rel > hold_hi);
        start    = (rel == spur_rel);
        if (rel == spur_rel) begin
            cfg_h = 6'd9;
            cfg_w = 6'd9;
            cfg_k = 2'd1;
            cfg_s = 2'd1;
        end
    endtask

    task automatic build_model(input vec_t v);
        int ho, wo;
        exp_rd.delete();
        exp_wr.delete();
        if (!v.err) begin
            ho = (v.h - v.k) / v.s + 1;
            wo = (v.w - v.k) / v.s + 1;
            for (int oy = 0; oy < ho; oy++)
                for (int ox = 0; ox < wo; ox++) begin
                    exp_wr.push_back((v.wb + oy * wo + ox) & 'hFFF);
                    for (int ky = 0; ky < v.k; ky++)
                        for (int kx = 0; kx < v.k; kx++)
                            exp_rd.push_back((v.rb + (oy * v.s + ky) * v.w + ox * v.s + kx) & 'hFFF);
                end
        end
    endtask

    // Called just after a falling edge: pulse start for cycle 0 and run past done.
    task automatic run_job(input vec_t v);
        rd_log.delete(); rdc_log.delete(); wr_log.delete();
        n_vld = 0; n_first = 0; n_last = 0; n_both = 0; n_done = 0; n_err = 0;
        first_vld = -1; done_cyc = -1; err_cyc = -1;
        busy1 = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
        busy_pre    = busy;
        cfg_h       = 6'(v.h);
        cfg_w       = 6'(v.w);
        cfg_k       = 2'(v.k);
        cfg_s       = 2'(v.s);
        cfg_rd_base = 12'(v.rb);
        cfg_wr_base = 12'(v.wb);
        start       = 1'b1;
        c0          = cyc;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_cyc >= 0 && (cyc - c0) >= done_cyc + 4) break;
        end
    endtask

    task automatic verify(input vec_t v);
        build_model(v);
        check("done_cycle", done_cyc, v.done_at);
        check("done_pulses", n_done, 1);
        check("cfg_err_cycle", err_cyc, v.err ? v.done_at : -1);
        check("cfg_err_pulses", n_err, v.err ? 1 : 0);
        check("read_count", rd_log.size(), v.reads);
        check_seq("rd_addr_seq", rd_log, exp_rd);
        check_seq("wr_addr_seq", wr_log, exp_wr);
        check("pool_vld_count", n_vld, v.reads);
        check("pool_first_count", n_first, v.wins);
        check("pool_last_count", n_last, v.wins);
        check("first_and_last", n_both, (v.k == 1) ? v.wins : 0);
        check("first_vld_cycle", first_vld, v.err ? -1 : 3);
        check("busy_idle", busy_pre, 0);
        check("busy_cycle1", busy1, 1);
        check("busy_at_done", busy_at_done, 1);
        check("busy_after_done", busy_after, 0);
    endtask

    initial begin
        int   lit1[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int   lit2[9]  = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        int   q_act[$], q_exp[$];
        vec_t vh;

        vecs[0]  = '{4, 4, 2, 2, 0, 100, 16, 4, 19, 1'b0};
        vecs[1]  = '{5, 5, 3, 1, 0, 0, 81, 9, 84, 1'b0};
        vecs[2]  = '{2, 2, 1, 1, 10, 200, 4, 4, 7, 1'b0};
        vecs[3]  = '{5, 7, 2, 3, 20, 50, 16, 4, 19, 1'b0};
        vecs[4]  = '{3, 3, 3, 3, 0, 7, 9, 1, 12, 1'b0};
        vecs[5]  = '{4, 4, 2, 2, 4090, 4094, 16, 4, 19, 1'b0};
        vecs[6]  = '{63, 1, 1, 1, 5, 0, 63, 63, 66, 1'b0};
        vecs[7]  = '{3, 63, 3, 3, 0, 0, 189, 21, 192, 1'b0};
        vecs[8]  = '{2, 2, 3, 1, 0, 0, 0, 0, 2, 1'b1};
        vecs[9]  = '{4, 4, 0, 1, 0, 0, 0, 0, 2, 1'b1};
        vecs[10] = '{4, 4, 2, 0, 0, 0, 0, 0, 2, 1'b1};
        vecs[11] = '{5, 2, 3, 1, 0, 0, 0, 0, 2, 1'b1};

        rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
        cfg_h = '0; cfg_w = '0; cfg_k = '0; cfg_s = '0; cfg_rd_base = '0; cfg_wr_base = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, done, cfg_err, rd_en, rd_addr, pool_vld,
                                     pool_first, pool_last, wr_addr}), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_job(vecs[i]);
            verify(vecs[i]);
            if (i == 0) begin
                q_act = rd_log;
                q_exp.delete();
                foreach (lit1[j]) q_exp.push_back(lit1[j]);
                check_seq("tile4x4_rd_literal", q_act, q_exp);
            end
            if (i == 1) begin
                q_act.delete();
                q_exp.delete();
                foreach (lit2[j]) begin
                    q_act.push_back(qget(rd_log, 9 + j));
                    q_exp.push_back(lit2[j]);
                end
                check_seq("second_window_rd", q_act, q_exp);
            end
        end

        // Backpressure at the second window: five read-less cycles, then resume at address 2.
        hold_lo = 5; hold_hi = 9;
        vh = vecs[0];
        vh.done_at = 24;
        run_job(vh);
        verify(vh);
        check("hold_last_read_before", qget(rdc_log, 3), 5);
        check("hold_resume_cycle", qget(rdc_log, 4), 11);
        check("hold_resume_addr", qget(rd_log, 4), 2);
        hold_lo = 1; hold_hi = 0;

        // Start pulses while busy (in RUN, then in CHECK) must be ignored.
        spur_rel = 4;
        run_job(vecs[0]);
        verify(vecs[0]);
        spur_rel = 1;
        run_job(vecs[8]);
        verify(vecs[8]);
        spur_rel = -1;

        // Asynchronous reset mid-RUN, reset winning over start, then a clean rerun.
        cfg_h = 6'd4; cfg_w = 6'd4; cfg_k = 2'd2; cfg_s = 2'd2;
        cfg_rd_base = 12'd0; cfg_wr_base = 12'd100;
        start = 1'b1;
        c0 = cyc;
        repeat (6) tick();
        check("pre_reset_rd_en", rd_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_run_reset_outputs", int'({busy, done, cfg_err, rd_en, rd_addr, pool_vld,
                                             pool_first, pool_last, wr_addr}), 0);
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("start_under_reset_busy", busy, 0);
        check("start_under_reset_rd_en", rd_en, 0);
        run_job(vecs[0]);
        verify(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencer for the pooling datapath in the TS3D accelerator. Given a feature-map tile configuration, it walks every K×K pooling window with stride S over an H×W plane. It issues one activation-buffer read per cycle and drives first/last/valid strobes aligned with read data into the POOL max-reduce datapath. It also supplies the write address for each pooled result, honouring backpressure from the output buffer.

## Interface
Parameters:
- ADDR_W, 12, activation/output buffer address width
- DIM_W, 6, width of H/W dimension fields (max 63)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when idle
- cfg_h, cfg_w  in  DIM_W  input plane height/width
- cfg_k  in  2  window size (legal 1..3)
- cfg_s  in  2  stride (legal 1..3)
- cfg_rd_base, cfg_wr_base  in  ADDR_W  buffer base addresses
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- cfg_err  out  1  one-cycle pulse with done on illegal config
- rd_en  out  1  activation read strobe
- rd_addr  out  ADDR_W  activation read address
- pool_vld, pool_first, pool_last  out  1  datapath strobes, aligned with read data (rd_en + 1)
- wr_addr  out  ADDR_W  output address, valid when pool_last=1
- wr_ready  in  1  output buffer can accept a result

## Operation
- States: IDLE, CHECK, RUN, HOLD, DRAIN, DONE.
- IDLE: start=1 latches config and moves to CHECK. start is ignored in any other state.
- CHECK (1 cycle): if k==0, s==0, k>h or k>w, go to DONE with cfg_err. Otherwise compute Ho=(h-k)/s+1 and Wo=(w-k)/s+1, clear counters, and go to RUN.
- Counters: ox, oy (output position); kx, ky (window offset).
  - kx is innermost, then ky, then ox, then oy.
- Read address: rd_addr = rd_base + (oy·s+ky)·w + (ox·s+kx), mod 2^ADDR_W.
  - Generate it incrementally (row-base and column registers). No multiplier on the per-cycle path.
- Write address: wr_addr = wr_base + oy·Wo + ox, mod 2^ADDR_W. It increments by 1 per window.
- RUN issues one read per cycle.
  - At kx=ky=0 (first read of a window), wr_ready is sampled. If it is 0, go to HOLD with no read issued.
  - HOLD returns to RUN, issuing that read, in the first cycle wr_ready=1.
  - wr_ready is not examined mid-window.
- After the read for the final window position (last ox, oy, kx, ky), go to DRAIN for 1 cycle, then DONE.
- DONE (1 cycle) pulses done and returns to IDLE.
- Strobes, registered from the read issue cycle:
  - pool_first marks kx=ky=0.
  - pool_last marks kx=ky=k−1.
  - k=1 asserts first and last together.
- Reset, including mid-operation: state IDLE, all counters cleared, every output 0. Reset takes priority over a simultaneous start.

## Timing
- Accepted start at cycle 0: CHECK at 1, first rd_en at 2, first pool_vld at 3.
- Windows run back-to-back with no bubble while wr_ready=1. Total read cycles = Ho·Wo·k².
- done is asserted 2 cycles after the last rd_en: DRAIN carries the last pool_vld, then DONE.
- Illegal config: cfg_err and done are asserted together at cycle 2. No rd_en is ever issued.
- busy is high from cycle 1 through the DONE cycle, and 0 after.
- All outputs are registered. No combinational path runs from wr_ready to rd_en, except the HOLD exit, which is registered one cycle later.

## Structure
- Shared package pool_pkg:
  - state enum
  - K_MAX=3, S_MAX=3
  - cfg struct (h, w, k, s, rd_base, wr_base)
  - Ho/Wo computation function
- Sub-module pool_addr_gen: the incremental row/column address counters for rd_addr and wr_addr, with load, step and window-wrap controls. pool_ctrl keeps the FSM and strobe pipeline.

## Test plan
- h=w=4, k=2, s=2, bases 0/100, wr_ready=1 → 16 reads.
  - rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - wr_addr 100..103 with pool_last.
  - done at cycle 19.
- h=w=5, k=3, s=1 → Ho=Wo=3, 81 reads.
  - Second window reads 1,2,3,6,7,8,11,12,13.
  - pool_first/pool_last each pulse 9 times.
- k=1, s=1, h=w=2 → 4 reads, each with pool_first=pool_last=1, wr_addr = base..base+3.
- wr_ready=0 for 5 cycles at the second window start → HOLD, no rd_en for 5 cycles, then resumes at addr 2. Total completion is delayed by exactly 5 cycles.
- k=3, h=2 → cfg_err and done at cycle 2, no rd_en. A start during busy is ignored.
- rst_n asserted mid-RUN → all outputs 0 immediately. A fresh start after release runs a full correct sequence.
